imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader: the write side of the instruction memory that the core's fetch/decode path reads.
//  Accepts a byte stream (valid/ready) and assembles little-endian 32-bit instruction words.
//  Writes the words sequentially into instruction memory, then checks a trailing 32-bit checksum.
//  Holds the core in reset for the whole load; releases it only on a successful load.
// PARAMETERS
//  ADDR_WIDTH  6  word-address width of instruction memory (depth = 2**ADDR_WIDTH words)
// PORTS
//  CLK           in   1             clock; all logic on rising edge
//  RST           in   1             synchronous, active-high reset
//  Load_Start    in   1             one-cycle pulse; starts a load (honoured only in IDLE/DONE/ERROR)
//  Load_Len      in   ADDR_WIDTH+1  number of instruction words; sampled with Load_Start
//  Byte_In       in   8             stream data byte
//  Byte_Valid    in   1             Byte_In valid
//  Byte_Ready    out  1             loader can accept a byte
//  IMem_WE       out  1             instruction memory write enable (one-cycle pulse per word)
//  IMem_Addr     out  ADDR_WIDTH    word address of the write
//  IMem_WData    out  32            instruction word to write
//  Core_Reset    out  1             hold the core in reset; high except in DONE
//  Busy          out  1             high in RECV/WRITE/CHECK
//  Load_Done     out  1             high in DONE (load and checksum OK)
//  Load_Error    out  1             high in ERROR (checksum mismatch or bad length)
// BEHAVIOUR
//  - Reset: state=IDLE; Byte_Ready=0, IMem_WE=0, IMem_Addr=0, IMem_WData=0, Core_Reset=1, Busy=0, Load_Done=0, Load_Error=0; byte cnt, word cnt, sum cleared.
//  - States: IDLE, RECV, WRITE, CHECK, DONE, ERROR.
//  - IDLE/DONE/ERROR + Load_Start: Load_Len==0 or Load_Len>2**ADDR_WIDTH -> ERROR next cycle.
//    Otherwise -> RECV; word cnt=0, byte cnt=0, sum=0, Load_Done=Load_Error=0, Core_Reset=1.
//  - Load_Start is ignored while Busy.
//  - RECV: Byte_Ready=1; a byte is accepted when Byte_Valid&&Byte_Ready.
//    Byte k (0..3) goes into bits [8k+7:8k] of the word (little-endian).
//    On acceptance of byte 3 -> WRITE.
//  - WRITE: exactly one cycle; Byte_Ready=0; IMem_WE=1, IMem_Addr=word cnt, IMem_WData=assembled word.
//    sum <= sum + word (mod 2**32); word cnt++.
//    If word cnt+1 == Load_Len -> CHECK, else -> RECV. Latency from byte 3 accepted to IMem_WE = 1 cycle.
//  - CHECK: Byte_Ready=1; assemble 4 bytes little-endian as the checksum, with no memory write.
//    On byte 3: if (sum + checksum) == 0 -> DONE, else -> ERROR.
//  - DONE: Core_Reset=0, Load_Done=1, Byte_Ready=0. ERROR: Core_Reset=1, Load_Error=1, Byte_Ready=0.
//  - Throughput: at most 4 bytes per 5 cycles (the WRITE cycle is a bubble); Byte_Valid may drop between bytes with no effect.
//  - Bytes presented while Byte_Ready=0 are not consumed; the source must hold them.
//  - Address wrap cannot occur: Load_Len is bounded at start, and the last word address is Load_Len-1.
//  - RST mid-load: immediately returns to the reset state. Words already written stay in memory; Core_Reset stays 1.
//  - IMem_Addr/IMem_WData are don't-care when IMem_WE=0, but they must not toggle outside WRITE (power).
// TESTING
//  - Reset: assert RST 2 cycles -> all outputs at reset values, Core_Reset=1, Byte_Ready=0.
//  - Load_Len=2, bytes 13 05 A0 00 | 93 05 10 00 | checksum 5A F5 4F FF
//    -> WE at addr0 with 0x00A00513, addr1 with 0x00100593; Load_Done=1, Core_Reset=0.
//  - Same stream, checksum 00 00 00 00 -> Load_Error=1, Core_Reset=1, both words still written.
//  - Byte_Valid toggled 1-0-1 at random, incl. during WRITE -> same writes, no byte lost or duplicated.
//  - Load_Len=0 -> ERROR next cycle, no WE. Load_Len=2**ADDR_WIDTH -> last write at addr 2**ADDR_WIDTH-1.
//  - RST after byte 2 of word 1 -> IDLE; a new Load_Start reloads from addr0 with clean assembly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side feeds bytes and observes memory writes; the slave side is the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 6
) ();

  logic [7:0]            Byte_In;
  logic                  Byte_Valid;
  logic                  Byte_Ready;
  logic                  IMem_WE;
  logic [ADDR_WIDTH-1:0] IMem_Addr;
  logic [31:0]           IMem_WData;

  modport master (
    output Byte_In,
    output Byte_Valid,
    input  Byte_Ready,
    input  IMem_WE,
    input  IMem_Addr,
    input  IMem_WData
  );

  modport slave (
    input  Byte_In,
    input  Byte_Valid,
    output Byte_Ready,
    output IMem_WE,
    output IMem_Addr,
    output IMem_WData
  );

endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Assembles little-endian 32-bit words from a byte stream and writes them to consecutive
// word addresses. A trailing 32-bit checksum must make the word sum wrap to zero. The core
// is held in reset until a load completes with a good checksum.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Load_Start,
  input  logic [ADDR_WIDTH:0]   Load_Len,
  imem_loader_if.slave          bus,
  output logic                  Core_Reset,
  output logic                  Busy,
  output logic                  Load_Done,
  output logic                  Load_Error
);

  // Largest legal word count: the full memory depth.
  localparam logic [ADDR_WIDTH:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e state_q, state_d;

  // Byte position within the current word (0..3).
  logic [1:0]            byte_cnt_q;
  // Words written so far; one bit wider so a full-depth load can reach Load_Len.
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [31:0]           sum_q;
  // Lower three bytes of the word being assembled; byte 3 comes straight from the bus.
  logic [23:0]           asm_q;
  // Write port registers; only loaded on entry to WRITE so they stay quiet otherwise.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic                  byte_ready;
  logic                  accept;
  logic                  last_byte;
  logic                  len_ok;
  logic                  start_ok;
  logic                  sum_ok;
  logic                  word_last;
  logic [31:0]           word_full;
  logic [ADDR_WIDTH:0]   word_cnt_inc;

  // Shared decode used by both the FSM and the datapath.
  always_comb begin
    accept       = bus.Byte_Valid && byte_ready;
    last_byte    = (byte_cnt_q == 2'd3);
    word_full    = {bus.Byte_In, asm_q};
    len_ok       = (Load_Len != '0) && (Load_Len <= MaxLen);
    start_ok     = Load_Start && len_ok;
    sum_ok       = ((sum_q + word_full) == 32'd0);
    word_cnt_inc = word_cnt_q + 1'b1;
    word_last    = (word_cnt_inc == len_q);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (Load_Start) begin
          state_d = len_ok ? StRecv : StError;
        end
      end
      StRecv: begin
        if (accept && last_byte) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = word_last ? StCheck : StRecv;
      end
      StCheck: begin
        if (accept && last_byte) begin
          state_d = sum_ok ? StDone : StError;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    byte_ready     = 1'b0;
    bus.IMem_WE    = 1'b0;
    Core_Reset     = 1'b1;
    Busy           = 1'b0;
    Load_Done      = 1'b0;
    Load_Error     = 1'b0;
    unique case (state_q)
      StRecv: begin
        byte_ready = 1'b1;
        Busy       = 1'b1;
      end
      StWrite: begin
        bus.IMem_WE = 1'b1;
        Busy        = 1'b1;
      end
      StCheck: begin
        byte_ready = 1'b1;
        Busy       = 1'b1;
      end
      StDone: begin
        Core_Reset = 1'b0;
        Load_Done  = 1'b1;
      end
      StError: begin
        Load_Error = 1'b1;
      end
      default: begin
        byte_ready = 1'b0;
      end
    endcase
    bus.Byte_Ready = byte_ready;
    bus.IMem_Addr  = addr_q;
    bus.IMem_WData = wdata_q;
  end

  // Datapath: byte assembly, word counting, checksum accumulation and write-port capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start_ok) begin
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= Load_Len;
            sum_q      <= '0;
            asm_q      <= '0;
          end
        end
        StRecv, StCheck: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    asm_q[7:0]   <= bus.Byte_In;
              2'd1:    asm_q[15:8]  <= bus.Byte_In;
              2'd2:    asm_q[23:16] <= bus.Byte_In;
              default: asm_q        <= asm_q;
            endcase
            // The checksum word is only compared, never written.
            if (last_byte && (state_q == StRecv)) begin
              addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
              wdata_q <= word_full;
            end
          end
        end
        StWrite: begin
          sum_q      <= sum_q + wdata_q;
          word_cnt_q <= word_cnt_inc;
        end
        default: begin
          sum_q <= sum_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios plus hand-written corner cases.
// Expected memory writes are queued as bytes are driven and checked when IMem_WE fires.
module tb_imem_loader;

  localparam int unsigned AW = 6;

  logic          clk;
  logic          rst;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          core_reset;
  logic          busy;
  logic          load_done;
  logic          load_error;

  int            checks;
  int            failures;
  int            skip_cnt;
  logic [37:0]   exp_q[$];
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .CLK        (clk),
    .RST        (rst),
    .Load_Start (load_start),
    .Load_Len   (load_len),
    .bus        (bus),
    .Core_Reset (core_reset),
    .Busy       (busy),
    .Load_Done  (load_done),
    .Load_Error (load_error)
  );

  typedef struct {
    int          len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] seed;
    bit          use_chk;
    logic [31:0] chk;
    bit          rnd;
    bit          exp_done;
  } vec_t;

  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset suppresses the quiet-bus check for the couple of samples around it.
  always @(posedge clk) begin
    if (rst) skip_cnt = 2;
  end

  // Write monitor: pops the scoreboard on every write; flags address/data toggling outside WRITE.
  always @(negedge clk) begin
    logic [37:0] e;
    if (bus.IMem_WE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", bus.IMem_Addr, e[37:32]);
        check("we_data", bus.IMem_WData, e[31:0]);
      end
    end else if (skip_cnt > 0) begin
      skip_cnt--;
    end else if (bus.IMem_Addr !== prev_addr || bus.IMem_WData !== prev_data) begin
      failures++;
      $display("FAIL quiet_bus: addr %0h data %0h changed from %0h %0h with WE low",
               bus.IMem_Addr, bus.IMem_WData, prev_addr, prev_data);
    end
    prev_addr = bus.IMem_Addr;
    prev_data = bus.IMem_WData;
  end

  function automatic logic [31:0] gen_word(input vec_t v, input int k);
    if (k == 0) return v.w0;
    if (k == 1) return v.w1;
    return v.seed ^ (k * 32'h9E37_79B9);
  endfunction

  // Offer one byte until it is taken; acceptance is judged from Ready before the edge.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit taken = 1'b0;
    int budget = 0;
    while (!taken && budget < 40) begin
      @(negedge clk);
      bus.Byte_In    = b;
      bus.Byte_Valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      taken = bus.Byte_Valid && bus.Byte_Ready;
      budget++;
      @(posedge clk);
    end
    if (!taken) check("byte_timeout", 1'b0, 1'b1);
  endtask

  task automatic start_load(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = (AW + 1)'(len);
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] w;
    logic [31:0] sum = 32'd0;
    logic [31:0] chk;
    start_load(v.len);
    check("busy_after_start", busy, 1'b1);
    for (int k = 0; k < v.len; k++) begin
      w = gen_word(v, k);
      sum += w;
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8], v.rnd);
      end
      exp_q.push_back({6'(k), w});
      #1;
      check("we_latency", bus.IMem_WE, 1'b1);
    end
    chk = v.use_chk ? v.chk : (32'd0 - sum);
    for (int b = 0; b < 4; b++) begin
      send_byte(chk[8*b +: 8], v.rnd);
    end
    @(negedge clk);
    bus.Byte_Valid = 1'b0;
    check("load_done", load_done, v.exp_done);
    check("load_error", load_error, !v.exp_done);
    check("core_reset", core_reset, !v.exp_done);
    check("busy_end", busy, 1'b0);
    check("ready_end", bus.Byte_Ready, 1'b0);
    check("all_words_written", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] w;
    checks         = 0;
    failures       = 0;
    skip_cnt       = 2;
    rst            = 1'b1;
    load_start     = 1'b0;
    load_len       = '0;
    bus.Byte_In    = 8'h00;
    bus.Byte_Valid = 1'b0;

    //           len w0            w1            seed          use  chk    rnd  done
    vecs[0] = '{2,   32'h00A00513, 32'h00100593, 32'h0,        1'b1, 32'hFF4FF55A, 1'b0, 1'b1};
    vecs[1] = '{2,   32'h00A00513, 32'h00100593, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0};
    vecs[2] = '{2,   32'h00A00513, 32'h00100593, 32'h0,        1'b1, 32'hFF4FF55A, 1'b1, 1'b1};
    vecs[3] = '{64,  32'h12345678, 32'h9ABCDEF0, 32'h5A5AC3C3, 1'b0, 32'h0,        1'b1, 1'b1};
    vecs[4] = '{5,   32'hDEADBEEF, 32'h00000001, 32'h0F0F1234, 1'b1, 32'h1,        1'b0, 1'b0};
    vecs[5] = '{1,   32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_ready", bus.Byte_Ready, 1'b0);
    check("rst_we", bus.IMem_WE, 1'b0);
    check("rst_addr", bus.IMem_Addr, 0);
    check("rst_wdata", bus.IMem_WData, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_error", load_error, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_load(vecs[i]);
    end

    // Zero and oversize lengths go straight to ERROR without writing.
    start_load(0);
    check("len0_error", load_error, 1'b1);
    check("len0_busy", busy, 1'b0);
    check("len0_core_reset", core_reset, 1'b1);
    start_load(65);
    check("len65_error", load_error, 1'b1);
    check("len65_busy", busy, 1'b0);

    // Partial load interrupted by reset after byte 2 of word 1.
    start_load(2);
    w = 32'h00A00513;
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
    exp_q.push_back({6'd0, w});
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    @(negedge clk);
    bus.Byte_Valid = 1'b0;
    load_start     = 1'b1;
    load_len       = '0;
    @(negedge clk);
    load_start = 1'b0;
    check("start_ignored_busy", busy, 1'b1);
    check("start_ignored_error", load_error, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", bus.Byte_Ready, 1'b0);
    check("midrst_core_reset", core_reset, 1'b1);
    check("midrst_addr", bus.IMem_Addr, 0);
    check("midrst_queue", exp_q.size(), 0);
    run_load(vecs[0]);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
